// File: rtl/req_conditioner.sv
// req_conditioner: front end of the 3-way grant arbiter.
// Turns single-cycle request pulses into per-requester pending counts,
// presents level requests, and retires one pending request per granted
// cycle. Reports service, wasted grants, overflow and starvation.
// Each requester is EMPTY (pend==0), PENDING (pend!=0, age<limit) or
// STARVED (pend!=0, age==limit). That state is carried by the pend and age
// counters themselves, so there is no separate state register.
module req_conditioner #(
   parameter int CNT_W        = 4,
   parameter int AGE_W        = 8,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           req_pulse,
   input  logic                 clr_ovf,
   input  logic [2:0]           granted_req,
   output logic [2:0]           req,
   output logic [2:0]           served,
   output logic                 wasted_grant,
   output logic [2:0]           overflow,
   output logic [2:0]           starve,
   output logic [3*CNT_W-1:0]   pend_cnt
);

   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
   localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_pend     [3];
   logic [CNT_W-1:0] w_pend_nxt [3];
   logic [AGE_W-1:0] r_age      [3];
   logic [AGE_W-1:0] w_age_nxt  [3];
   logic [2:0]       w_dec;
   logic [2:0]       w_ovf_set;
   logic [2:0]       r_served;
   logic             r_wasted;
   logic [2:0]       r_ovf;

   // Next pend/age per requester from the pulse/grant pair.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         // NOTE: every output of this block gets a default first, so no path
         // leaves a value unassigned and no latch is inferred.
         w_dec[i]      = granted_req[i] & (r_pend[i] != '0);
         w_pend_nxt[i] = r_pend[i];
         w_ovf_set[i]  = 1'b0;
         w_age_nxt[i]  = '0;

         if (req_pulse[i] && !w_dec[i]) begin
            if (r_pend[i] != PEND_MAX)
               w_pend_nxt[i] = r_pend[i] + CNT_W'(1);
            else
               w_ovf_set[i] = 1'b1;
         end else if (!req_pulse[i] && w_dec[i]) begin
            w_pend_nxt[i] = r_pend[i] - CNT_W'(1);
         end

         // A grant restarts the wait; an idle requester has no age; otherwise
         // age counts up and parks at the starvation limit.
         if (w_dec[i])
            w_age_nxt[i] = '0;
         else if (r_pend[i] != '0)
            w_age_nxt[i] = (r_age[i] == AGE_LIM) ? r_age[i] : r_age[i] + AGE_W'(1);
         else
            w_age_nxt[i] = '0;
      end
   end

   // Counter, flag and pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the small per-requester counter arrays are reset explicitly;
         // a reset must discard all pending work, so they cannot be left as
         // uninitialised storage.
         for (int i = 0; i < 3; i++) begin
            r_pend[i] <= '0;
            r_age[i]  <= '0;
         end
         r_served <= '0;
         r_wasted <= 1'b0;
         r_ovf    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading the
         // pre-edge values, independent of statement order.
         for (int i = 0; i < 3; i++) begin
            r_pend[i] <= w_pend_nxt[i];
            r_age[i]  <= w_age_nxt[i];
         end
         r_served <= w_dec;
         r_wasted <= |(granted_req & ~req);
         // A dropped pulse in the same cycle as clr_ovf keeps the flag set.
         r_ovf    <= (r_ovf & ~{3{clr_ovf}}) | w_ovf_set;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req[i]    = (r_pend[i] != '0);
         starve[i] = (r_age[i] == AGE_LIM);
      end
   end

   assign served       = r_served;
   assign wasted_grant = r_wasted;
   assign overflow     = r_ovf;
   assign pend_cnt     = {r_pend[2], r_pend[1], r_pend[0]};

endmodule

// File: tb/tb_req_conditioner.sv
// Bench for req_conditioner: directed vectors, with served/wasted_grant
// pulses checked through an expectation queue drained by a monitor.
module tb_req_conditioner;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_pulse;
   logic        clr_ovf;
   logic [2:0]  granted_req;
   logic [2:0]  req;
   logic [2:0]  served;
   logic        wasted_grant;
   logic [2:0]  overflow;
   logic [2:0]  starve;
   logic [11:0] pend_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected {served, wasted_grant} pulses, in issue order.
   logic [3:0] exp_q[$];

   req_conditioner #(.CNT_W(4), .AGE_W(8), .STARVE_LIMIT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_pulse    (req_pulse),
      .clr_ovf      (clr_ovf),
      .granted_req  (granted_req),
      .req          (req),
      .served       (served),
      .wasted_grant (wasted_grant),
      .overflow     (overflow),
      .starve       (starve),
      .pend_cnt     (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic expect_pulse(input logic [2:0] s, input logic w);
      exp_q.push_back({s, w});
   endtask

   // Apply one cycle of inputs; return 1 time unit after the sampling edge.
   task automatic cyc(input logic [2:0] rp, input logic [2:0] g, input logic c);
      req_pulse   = rp;
      granted_req = g;
      clr_ovf     = c;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse the DUT presents must match the next expectation.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && (served !== 3'b000 || wasted_grant !== 1'b0)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {28'd0, served, wasted_grant}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pulse", {28'd0, served, wasted_grant}, {28'd0, e});
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      req_pulse   = '0;
      clr_ovf     = 1'b0;
      granted_req = '0;
      @(posedge clk); @(posedge clk); #1;

      // Reset state.
      check("rst_req",      {29'd0, req},          32'd0);
      check("rst_pend",     {20'd0, pend_cnt},     32'd0);
      check("rst_ovf",      {29'd0, overflow},     32'd0);
      check("rst_starve",   {29'd0, starve},       32'd0);
      check("rst_served",   {29'd0, served},       32'd0);
      check("rst_wasted",   {31'd0, wasted_grant}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Single pulse, arbiter grants on the following two cycles.
      cyc(3'b001, 3'b000, 1'b0);
      check("t2_req",  {29'd0, req},      32'h1);
      check("t2_pend", {20'd0, pend_cnt}, 32'h001);
      expect_pulse(3'b001, 1'b0);
      cyc(3'b000, 3'b001, 1'b0);
      check("t2_pend_drained", {20'd0, pend_cnt}, 32'h000);
      check("t2_req_low",      {29'd0, req},      32'h0);
      expect_pulse(3'b000, 1'b1);
      cyc(3'b000, 3'b001, 1'b0);
      check("t2_pend_stays0",  {20'd0, pend_cnt}, 32'h000);
      cyc(3'b000, 3'b000, 1'b0);

      // Grant to an idle requester.
      expect_pulse(3'b000, 1'b1);
      cyc(3'b000, 3'b010, 1'b0);
      check("t6_pend",   {20'd0, pend_cnt}, 32'h000);
      check("t6_served", {29'd0, served},   32'h0);
      cyc(3'b000, 3'b000, 1'b0);

      // Saturate requester 1, overflow set-wins, then clear.
      for (int k = 0; k < 15; k++) cyc(3'b010, 3'b000, 1'b0);
      check("t3_pend15",    {20'd0, pend_cnt}, 32'h0F0);
      check("t3_no_ovf",    {29'd0, overflow}, 32'h0);
      cyc(3'b010, 3'b000, 1'b0);
      check("t3_pend_sat",  {20'd0, pend_cnt}, 32'h0F0);
      check("t3_ovf_set",   {29'd0, overflow}, 32'h2);
      cyc(3'b010, 3'b000, 1'b1);
      check("t3_set_wins",  {29'd0, overflow}, 32'h2);
      cyc(3'b000, 3'b000, 1'b1);
      check("t3_ovf_clr",   {29'd0, overflow}, 32'h0);
      check("t3_pend_kept", {20'd0, pend_cnt}, 32'h0F0);
      check("t3_starve1",   {29'd0, starve},   32'h2);
      expect_pulse(3'b010, 1'b0);
      cyc(3'b000, 3'b010, 1'b0);
      check("t3_starve_clr", {29'd0, starve},  32'h0);
      for (int k = 0; k < 14; k++) begin
         expect_pulse(3'b010, 1'b0);
         cyc(3'b000, 3'b010, 1'b0);
      end
      check("t3_drained", {20'd0, pend_cnt}, 32'h000);
      cyc(3'b000, 3'b000, 1'b0);

      // Requester 2 at max: simultaneous pulse and grant.
      for (int k = 0; k < 15; k++) cyc(3'b100, 3'b000, 1'b0);
      check("t4_pend15", {20'd0, pend_cnt}, 32'hF00);
      expect_pulse(3'b100, 1'b0);
      cyc(3'b100, 3'b100, 1'b0);
      check("t4_pend_hold", {20'd0, pend_cnt}, 32'hF00);
      check("t4_no_ovf",    {29'd0, overflow}, 32'h0);
      for (int k = 0; k < 15; k++) begin
         expect_pulse(3'b100, 1'b0);
         cyc(3'b000, 3'b100, 1'b0);
      end
      check("t4_drained", {20'd0, pend_cnt}, 32'h000);
      cyc(3'b000, 3'b000, 1'b0);

      // Starvation of requester 2 while grants go to idle requester 0.
      cyc(3'b100, 3'b000, 1'b0);
      for (int k = 0; k < 15; k++) begin
         expect_pulse(3'b000, 1'b1);
         cyc(3'b000, 3'b001, 1'b0);
      end
      check("t5_not_yet", {29'd0, starve}, 32'h0);
      expect_pulse(3'b000, 1'b1);
      cyc(3'b000, 3'b001, 1'b0);
      check("t5_starved", {29'd0, starve},   32'h4);
      check("t5_pend",    {20'd0, pend_cnt}, 32'h100);
      expect_pulse(3'b100, 1'b0);
      cyc(3'b000, 3'b100, 1'b0);
      check("t5_unstarved", {29'd0, starve},   32'h0);
      check("t5_pend0",     {20'd0, pend_cnt}, 32'h000);
      cyc(3'b000, 3'b000, 1'b0);
      cyc(3'b000, 3'b000, 1'b0);

      // Asynchronous reset mid-burst with pend0=5.
      for (int k = 0; k < 5; k++) cyc(3'b001, 3'b000, 1'b0);
      check("t1_pend5", {20'd0, pend_cnt}, 32'h005);
      cyc(3'b001, 3'b001, 1'b0);
      #1;
      reset       = 1'b0;
      req_pulse   = '0;
      granted_req = '0;
      #1;
      check("t1_req_async",    {29'd0, req},      32'h0);
      check("t1_pend_async",   {20'd0, pend_cnt}, 32'h000);
      check("t1_served_async", {29'd0, served},   32'h0);
      check("t1_starve_async", {29'd0, starve},   32'h0);
      @(negedge clk);
      reset = 1'b1;
      cyc(3'b000, 3'b000, 1'b0);
      cyc(3'b000, 3'b000, 1'b0);
      check("t1_after_release", {20'd0, pend_cnt}, 32'h000);

      check("pulses_outstanding", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
